ssd_scan_ctl: RTL and testbench



---
 rtl/ssd_scan_ctl.sv | 136 +++++++++++++
 tb/tb_ssd_scan_ctl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctl.sv
// Four-digit common-anode seven-segment scan controller.
// Double-buffered patterns commit only at frame boundaries; guard slot blanks each digit switch.
module ssd_scan_ctl #(
    parameter int SLOT_CYC = 100000,
    parameter int GUARD    = 4,
    parameter int CW       = $clog2(SLOT_CYC)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic [3:0] blank,
    input  logic       load,
    input  logic       en,
    output logic [3:0] ssd_ctl,
    output logic [7:0] ssd_out,
    output logic       load_ack,
    output logic       frame_tick
);

    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          pending_q, pending_d;

    logic [7:0]    stg_q [4];
    logic [7:0]    stg_d [4];
    logic [3:0]    stg_blank_q, stg_blank_d;

    logic [7:0]    shd_q [4];
    logic [7:0]    shd_d [4];
    logic [3:0]    shd_blank_q, shd_blank_d;

    logic [3:0]    ssd_ctl_q, ssd_ctl_d;
    logic [7:0]    ssd_out_q, ssd_out_d;
    logic          load_ack_q, load_ack_d;
    logic          frame_tick_q, frame_tick_d;

    logic [7:0]    seg_in [4];
    logic          slot_end;
    logic          boundary;
    logic          commit;
    logic          in_guard;
    logic          dark;

    always_comb begin
        seg_in[0] = seg0;
        seg_in[1] = seg1;
        seg_in[2] = seg2;
        seg_in[3] = seg3;
    end

    // Scan position: counters free-run independent of en and blank.
    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        boundary = slot_end && (idx_q == 2'd3);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
    end

    // Staging/shadow double buffer; a load on the boundary bypasses staging.
    always_comb begin
        commit      = boundary && (pending_q || load);
        stg_d       = stg_q;
        stg_blank_d = stg_blank_q;
        shd_d       = shd_q;
        shd_blank_d = shd_blank_q;
        pending_d   = pending_q;
        if (load) begin
            stg_d       = seg_in;
            stg_blank_d = blank;
            pending_d   = 1'b1;
        end
        if (commit) begin
            pending_d = 1'b0;
            if (load) begin
                shd_d       = seg_in;
                shd_blank_d = blank;
            end else begin
                shd_d       = stg_q;
                shd_blank_d = stg_blank_q;
            end
        end
    end

    // Outputs follow the next-state position so they move with cnt/idx.
    always_comb begin
        in_guard     = (GUARD > 0) && (int'({1'b0, cnt_d}) < GUARD);
        dark         = in_guard || !en || shd_blank_d[idx_d];
        ssd_ctl_d    = 4'b1111;
        ssd_out_d    = 8'hFF;
        if (!dark) begin
            ssd_ctl_d = ~(4'b0001 << idx_d);
            ssd_out_d = shd_d[idx_d];
        end
        load_ack_d   = commit;
        frame_tick_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            pending_q    <= 1'b0;
            stg_q        <= '{default: 8'hFF};
            stg_blank_q  <= 4'b0000;
            shd_q        <= '{default: 8'hFF};
            shd_blank_q  <= 4'b0000;
            ssd_ctl_q    <= 4'b1111;
            ssd_out_q    <= 8'hFF;
            load_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            stg_q        <= stg_d;
            stg_blank_q  <= stg_blank_d;
            shd_q        <= shd_d;
            shd_blank_q  <= shd_blank_d;
            ssd_ctl_q    <= ssd_ctl_d;
            ssd_out_q    <= ssd_out_d;
            load_ack_q   <= load_ack_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign ssd_ctl    = ssd_ctl_q;
    assign ssd_out    = ssd_out_q;
    assign load_ack   = load_ack_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Bench for ssd_scan_ctl: directed scenarios then random traffic,
// checked every cycle against a frame-position reference model.
module tb_ssd_scan_ctl;

    localparam int SLOT  = 8;
    localparam int GRD   = 2;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg0, seg1, seg2, seg3;
    logic [3:0] blank;
    logic       load;
    logic       en;
    logic [3:0] ssd_ctl;
    logic [7:0] ssd_out;
    logic       load_ack;
    logic       frame_tick;

    ssd_scan_ctl #(.SLOT_CYC(SLOT), .GUARD(GRD)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .blank      (blank),
        .load       (load),
        .en         (en),
        .ssd_ctl    (ssd_ctl),
        .ssd_out    (ssd_out),
        .load_ack   (load_ack),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: t = cycles since reset released, position = t mod FRAME.
    int         t;
    logic [7:0] m_stg [4];
    logic [7:0] m_shd [4];
    logic [3:0] m_stgb, m_shdb;
    bit         m_pend;
    logic [3:0] e_ctl;
    logic [7:0] e_out;
    logic       e_ack, e_tick;
    int         ack_seen;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp_v);
        end
    endtask

    task automatic model_edge();
        logic [7:0] in_v [4];
        bit bnd, cmt;
        int slot, c;
        in_v = '{seg0, seg1, seg2, seg3};
        if (rst) begin
            t      = 0;
            m_stg  = '{default: 8'hFF};
            m_shd  = '{default: 8'hFF};
            m_stgb = 4'b0000;
            m_shdb = 4'b0000;
            m_pend = 0;
            e_ctl  = 4'b1111;
            e_out  = 8'hFF;
            e_ack  = 0;
            e_tick = 0;
            return;
        end
        bnd = (t % FRAME) == FRAME - 1;
        cmt = bnd && (m_pend || load);
        if (cmt) begin
            m_shd  = load ? in_v : m_stg;
            m_shdb = load ? blank : m_stgb;
        end
        if (load) begin
            m_stg  = in_v;
            m_stgb = blank;
        end
        m_pend = cmt ? 0 : (load ? 1 : m_pend);
        t++;
        slot = (t % FRAME) / SLOT;
        c    = t % SLOT;
        if (c < GRD || !en || m_shdb[slot]) begin
            e_ctl = 4'b1111;
            e_out = 8'hFF;
        end else begin
            e_ctl = ~(4'b0001 << slot);
            e_out = m_shd[slot];
        end
        e_ack  = cmt;
        e_tick = bnd;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("ssd_ctl", {4'h0, ssd_ctl}, {4'h0, e_ctl});
        chk("ssd_out", ssd_out, e_out);
        chk("load_ack", {7'd0, load_ack}, {7'd0, e_ack});
        chk("frame_tick", {7'd0, frame_tick}, {7'd0, e_tick});
        if (load_ack) ack_seen++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) step();
    endtask

    task automatic do_load(input logic [7:0] s0, s1, s2, s3, input logic [3:0] b);
        seg0  = s0;
        seg1  = s1;
        seg2  = s2;
        seg3  = s3;
        blank = b;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        en    = 1'b1;
        blank = 4'b0000;
        {seg0, seg1, seg2, seg3} = '1;
        t = 0;
        ack_seen = 0;

        // Reset, then an idle frame: dark throughout, first tick at cycle 32.
        steps(3);
        rst = 1'b0;
        steps(FRAME + 1);
        chk("first_tick_pos", 8'(t % FRAME), 8'd1);

        // Basic scan.
        do_load(8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 4'b0000);
        steps(3 * FRAME);

        // Tear-free update: two loads in slot 1, one ack at next frame.
        run_to(SLOT + 1);
        ack_seen = 0;
        do_load(8'h99, 8'b10011111, 8'b00100101, 8'b00001101, 4'b0000);
        steps(2);
        do_load(8'h49, 8'b10011111, 8'b00100101, 8'b00001101, 4'b0000);
        steps(FRAME + 4);
        chk("single_ack", 8'(ack_seen), 8'd1);

        // Load on the boundary cycle itself.
        run_to(FRAME - 1);
        do_load(8'h49, 8'b10011111, 8'b00100101, 8'b11111101, 4'b0000);
        chk("boundary_ack", {7'd0, load_ack}, 8'd1);
        steps(FRAME);

        // Blank mask on digit 3, then display disabled.
        do_load(8'h49, 8'h9F, 8'h25, 8'hFD, 4'b1000);
        steps(2 * FRAME);
        en = 1'b0;
        steps(2 * FRAME);
        en = 1'b1;

        // Reset mid-frame with a load pending.
        run_to(SLOT + 2);
        do_load(8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);
        run_to(2 * SLOT + 5);
        ack_seen = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(2 * FRAME);
        chk("no_ack_after_rst", 8'(ack_seen), 8'd0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            seg0  = 8'($urandom);
            seg1  = 8'($urandom);
            seg2  = 8'($urandom);
            seg3  = 8'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            load  = ($urandom_range(0, 11) == 0);
            en    = ($urandom_range(0, 15) != 0);
            rst   = ($urandom_range(0, 400) == 0);
            step();
        end
        rst  = 1'b0;
        load = 1'b0;
        steps(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
